// File: rtl/pooled_fm_reader_pkg.sv
// Shared widths and FSM encoding for the pooled feature-map read path.
package pooled_fm_reader_pkg;

    localparam int CFG_W_SIZE    = 8;
    localparam int CFG_W_CHANNEL = 6;
    localparam int FM_BUFFER_DW  = 64;
    localparam int FM_BUFFER_AW  = 12;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } fsm_state_e;

endpackage

// File: rtl/pooled_fm_reader_fm_skid_fifo.sv
// Two-entry FIFO; entry 0 is the registered output beat.
module fm_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         vld_o,
    output logic [1:0]   cnt_o
);

    logic [W-1:0] e0_q;
    logic [W-1:0] e1_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push_i) begin
                        e0_q  <= din_i;
                        cnt_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push_i && pop_i) begin
                        e0_q <= din_i;
                    end else if (push_i) begin
                        e1_q  <= din_i;
                        cnt_q <= 2'd2;
                    end else if (pop_i) begin
                        cnt_q <= 2'd0;
                    end
                end
                2'd2: begin
                    // Never pushed while full without a pop.
                    if (pop_i) begin
                        e0_q <= e1_q;
                        if (push_i) e1_q <= din_i;
                        else cnt_q <= 2'd1;
                    end
                end
                default: cnt_q <= 2'd0;
            endcase
        end
    end

    assign dout_o = e0_q;
    assign vld_o  = (cnt_q != 2'd0);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/pooled_fm_reader.sv
// Reads a pooled map back in (tile, row, col) order with back-pressure.
module pooled_fm_reader
    import pooled_fm_reader_pkg::*;
#(
    parameter int W_SIZE    = CFG_W_SIZE,
    parameter int W_CHANNEL = CFG_W_CHANNEL,
    parameter int OFM_DW    = FM_BUFFER_DW,
    parameter int OFM_AW    = FM_BUFFER_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W_SIZE-1:0]    q_width,
    input  logic [W_SIZE-1:0]    q_height,
    input  logic [W_CHANNEL-1:0] q_channel_out,
    input  logic [OFM_AW-1:0]    q_base_addr,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_rd_en,
    output logic [OFM_AW-1:0]    o_rd_addr,
    input  logic [OFM_DW-1:0]    i_rd_data,
    output logic                 o_data_vld,
    output logic [OFM_DW-1:0]    o_data,
    output logic [W_SIZE-1:0]    o_row,
    output logic [W_SIZE-1:0]    o_col,
    output logic [W_CHANNEL-1:0] o_chn,
    output logic                 o_last,
    input  logic                 i_data_rdy
);

    localparam int TW = 1 + W_CHANNEL + 2 * W_SIZE + OFM_DW;

    fsm_state_e           state_q;
    logic [W_SIZE-1:0]    width_q, height_q, row_q, col_q;
    logic [W_CHANNEL-1:0] chn_num_q, chn_q;
    logic [OFM_AW-1:0]    tile_q, addr_q;
    logic                 zero_q, inflight_q;
    logic [W_SIZE-1:0]    tag_row_q, tag_col_q;
    logic [W_CHANNEL-1:0] tag_chn_q;
    logic                 tag_last_q;

    logic [TW-1:0]        push_d, fifo_dout;
    logic [1:0]           fifo_cnt;
    logic [2:0]           occ_d;
    logic                 pop, issue;
    logic                 last_col, last_row, last_chn, last_pix;
    logic [OFM_AW-1:0]    stride;

    assign pop      = o_data_vld && i_data_rdy;
    assign occ_d    = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue    = (state_q == S_RUN) && !zero_q && (occ_d < 3'd2);
    assign last_col = (col_q == width_q - W_SIZE'(1));
    assign last_row = (row_q == height_q - W_SIZE'(1));
    assign last_chn = (chn_q == chn_num_q - W_CHANNEL'(1));
    assign last_pix = last_col && last_row && last_chn;
    assign stride   = OFM_AW'(chn_num_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            width_q    <= '0;
            height_q   <= '0;
            chn_num_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            chn_q      <= '0;
            tile_q     <= '0;
            addr_q     <= '0;
            zero_q     <= 1'b0;
            inflight_q <= 1'b0;
            tag_row_q  <= '0;
            tag_col_q  <= '0;
            tag_chn_q  <= '0;
            tag_last_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        width_q   <= q_width;
                        height_q  <= q_height;
                        chn_num_q <= q_channel_out;
                        zero_q    <= (q_width == '0) || (q_height == '0)
                                     || (q_channel_out == '0);
                        tile_q    <= q_base_addr;
                        addr_q    <= q_base_addr;
                        row_q     <= '0;
                        col_q     <= '0;
                        chn_q     <= '0;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (zero_q) begin
                        state_q <= S_DONE;
                    end else if (issue) begin
                        tag_row_q  <= row_q;
                        tag_col_q  <= col_q;
                        tag_chn_q  <= chn_q;
                        tag_last_q <= last_pix;
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                row_q  <= '0;
                                chn_q  <= chn_q + W_CHANNEL'(1);
                                tile_q <= tile_q + OFM_AW'(1);
                                addr_q <= tile_q + OFM_AW'(1);
                            end else begin
                                row_q  <= row_q + W_SIZE'(1);
                                addr_q <= addr_q + stride;
                            end
                        end else begin
                            col_q  <= col_q + W_SIZE'(1);
                            addr_q <= addr_q + stride;
                        end
                        if (last_pix) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leave as the final beat is popped so done follows it directly.
                    if (!inflight_q && (fifo_cnt == 2'd0
                        || (fifo_cnt == 2'd1 && pop))) begin
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign push_d = {tag_last_q, tag_chn_q, tag_row_q, tag_col_q, i_rd_data};

    fm_skid_fifo #(
        .W(TW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push_i(inflight_q),
        .din_i (push_d),
        .pop_i (pop),
        .dout_o(fifo_dout),
        .vld_o (o_data_vld),
        .cnt_o (fifo_cnt)
    );

    assign {o_last, o_chn, o_row, o_col, o_data} = fifo_dout;
    assign o_rd_en   = issue;
    assign o_rd_addr = addr_q;
    assign o_busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign o_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_pooled_fm_reader.sv
// Randomized and directed bench for pooled_fm_reader with a loop-based map model.
module tb_pooled_fm_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  q_width = '0, q_height = '0;
    logic [5:0]  q_channel_out = '0;
    logic [11:0] q_base_addr = '0;
    logic        i_start = 1'b0;
    logic        o_busy, o_done, o_rd_en;
    logic [11:0] o_rd_addr;
    logic [63:0] i_rd_data = '0;
    logic        o_data_vld;
    logic [63:0] o_data;
    logic [7:0]  o_row, o_col;
    logic [5:0]  o_chn;
    logic        o_last;
    logic        i_data_rdy = 1'b1;

    int total = 0;
    int bad = 0;
    logic [63:0] salt = '0;

    typedef struct {
        logic [63:0] d;
        int r;
        int col;
        int ch;
        int last;
    } beat_t;

    pooled_fm_reader dut (
        .clk(clk), .rst(rst),
        .q_width(q_width), .q_height(q_height),
        .q_channel_out(q_channel_out), .q_base_addr(q_base_addr),
        .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_data_vld(o_data_vld), .o_data(o_data),
        .o_row(o_row), .o_col(o_col), .o_chn(o_chn), .o_last(o_last),
        .i_data_rdy(i_data_rdy)
    );

    always #5 clk = ~clk;

    // Buffer model: contents are the address tagged with a per-run salt.
    always @(posedge clk) if (o_rd_en) i_rd_data <= salt | 64'(o_rd_addr);

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctl"}, {60'd0, o_busy, o_done, o_rd_en, o_data_vld}, 64'd0);
        check({tag, "_addr"}, 64'(o_rd_addr), 64'd0);
        check({tag, "_data"}, o_data, 64'd0);
        check({tag, "_tags"}, {43'd0, o_last, o_chn, o_row, o_col}, 64'd0);
    endtask

    // mode: 0 always ready, 1 random 50%, 2 stall 5 cycles after beat 1
    task automatic run_map(input int w, input int h, input int c,
                           input int base, input int mode,
                           input int rst_at, input bit dbl_start);
        beat_t exq[$];
        int exa[$];
        beat_t e;
        int n, beats, reads, first_rd, first_vld, last_n, done_n;
        int stall_left, budget, nbeats;
        bit prev_hold;
        logic [63:0] prev_d, prev_t;
        nbeats = w * h * c;
        salt = 64'($urandom) << 32;
        for (int ch = 0; ch < c; ch++)
            for (int r = 0; r < h; r++)
                for (int x = 0; x < w; x++) begin
                    int a;
                    a = (base + ch + (r * w + x) * c) & 'hFFF;
                    exa.push_back(a);
                    e.d = salt | 64'(a);
                    e.r = r;
                    e.col = x;
                    e.ch = ch;
                    e.last = (ch == c - 1 && r == h - 1 && x == w - 1) ? 1 : 0;
                    exq.push_back(e);
                end
        @(negedge clk);
        q_width = 8'(w);
        q_height = 8'(h);
        q_channel_out = 6'(c);
        q_base_addr = 12'(base);
        i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        n = 0; beats = 0; reads = 0; first_rd = -1; first_vld = -1;
        last_n = -1; done_n = -1; stall_left = 5; prev_hold = 0;
        prev_d = '0; prev_t = '0;
        budget = 20 * nbeats + 40;
        while (done_n < 0 && n < budget) begin
            n++;
            @(negedge clk);
            if (dbl_start) i_start = (n == 5);
            if (mode == 1) i_data_rdy = 1'($urandom_range(0, 1));
            else if (mode == 2) begin
                i_data_rdy = !(beats >= 1 && stall_left > 0);
                if (!i_data_rdy) stall_left--;
            end else i_data_rdy = 1'b1;
            #1;
            if (n == 1) check("busy_c1", 64'(o_busy), 64'd1);
            if (o_rd_en) begin
                reads++;
                if (first_rd < 0) first_rd = n;
                if (exa.size() > 0) check("rd_addr", 64'(o_rd_addr), 64'(exa.pop_front()));
                else check("rd_count", 64'(reads), 64'(nbeats));
            end
            if (prev_hold) begin
                check("hold_vld", 64'(o_data_vld), 64'd1);
                check("hold_data", o_data, prev_d);
                check("hold_tags", {43'd0, o_last, o_chn, o_row, o_col}, prev_t);
            end
            if (o_data_vld && first_vld < 0) first_vld = n;
            if (o_data_vld && i_data_rdy) begin
                beats++;
                last_n = n;
                if (exq.size() > 0) begin
                    e = exq.pop_front();
                    check("data", o_data, e.d);
                    check("row", 64'(o_row), 64'(e.r));
                    check("col", 64'(o_col), 64'(e.col));
                    check("chn", 64'(o_chn), 64'(e.ch));
                    check("last", 64'(o_last), 64'(e.last));
                end else check("beat_count", 64'(beats), 64'(nbeats));
            end
            check("outstanding_le2", 64'(reads - beats <= 2), 64'd1);
            prev_hold = o_data_vld && !i_data_rdy;
            prev_d = o_data;
            prev_t = {43'd0, o_last, o_chn, o_row, o_col};
            if (o_done) begin
                done_n = n;
                check("busy_at_done", 64'(o_busy), 64'd0);
            end
            if (rst_at > 0 && beats == rst_at) break;
        end
        i_start = 1'b0;
        if (rst_at > 0) begin
            check("rst_reached", 64'(beats), 64'(rst_at));
            rst = 1'b1;
            #1 check_zero_outputs("rst_mid_a");
            @(posedge clk);
            #1 check_zero_outputs("rst_mid_b");
            @(negedge clk);
            rst = 1'b0;
            i_data_rdy = 1'b1;
            return;
        end
        check("done_seen", 64'(done_n >= 0), 64'd1);
        check("beats", 64'(beats), 64'(nbeats));
        check("reads", 64'(reads), 64'(nbeats));
        if (nbeats == 0) begin
            check("zero_done_lat", 64'(done_n), 64'd2);
            check("zero_no_rd", 64'(first_rd), 64'(-1));
            check("zero_no_vld", 64'(first_vld), 64'(-1));
        end else begin
            check("done_lat", 64'(done_n), 64'(last_n + 1));
            check("first_rd", 64'(first_rd), 64'd1);
            if (mode == 0) check("first_vld", 64'(first_vld), 64'd3);
            if (mode == 0) check("no_bubbles", 64'(last_n - first_vld + 1), 64'(nbeats));
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("post_quiet", {60'd0, o_busy, o_done, o_rd_en, o_data_vld}, 64'd0);
        end
    endtask

    initial begin
        #1 check_zero_outputs("reset");
        @(posedge clk);
        #1 check_zero_outputs("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        run_map(2, 2, 2, 'h100, 0, 0, 1'b0);
        run_map(4, 1, 1, $urandom_range(0, 4095), 2, 0, 1'b0);
        run_map(8, 8, 4, $urandom_range(0, 4095), 1, 0, 1'b0);
        run_map(5, 0, 3, 'h040, 0, 0, 1'b0);
        run_map(4, 4, 4, 'h200, 0, 10, 1'b0);
        run_map(4, 4, 4, 'h200, 0, 0, 1'b0);
        run_map(3, 2, 2, 'hFFE, 0, 0, 1'b1);
        for (int t = 0; t < 3; t++)
            run_map($urandom_range(1, 6), $urandom_range(1, 5),
                    $urandom_range(1, 4), $urandom_range(0, 4095), 1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
